alu_operand_loader: RTL

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_loader_timeout.sv | 37 +++
 rtl/alu_operand_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the UART-fed ALU operand loader: frame header, opcodes, FSM states.
// ALU_LOADER_CHECKSUM_EN adds the CHECK state to the state encoding.
package alu_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef logic [7:0] opcode_t;

  localparam opcode_t OP_ADD = 8'h01;
  localparam opcode_t OP_SUB = 8'h02;
  localparam opcode_t OP_AND = 8'h03;
  localparam opcode_t OP_OR  = 8'h04;
  localparam opcode_t OP_XOR = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_A_BYTES,
    ST_B_BYTES,
`ifdef ALU_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_ISSUE
  } ld_state_e;

endpackage

// File: rtl/alu_loader_timeout.sv
// Saturating idle-cycle counter; expired_o is high while the count equals TIMEOUT_CYCLES.
// Clear has priority over enable.
module alu_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/alu_operand_loader.sv
// Assembles header/opcode/A/B byte frames from a UART into a held operand set with valid/ready handoff.
// Optional trailing XOR checksum byte when ALU_LOADER_CHECKSUM_EN is defined.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int N              = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   opcode,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         err_timeout,
  output logic         err_checksum,
  output logic         err_overrun
);

  localparam int NB = N / 8;

  ld_state_e    state_q, state_d;
  opcode_t      opcode_q, opcode_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]   idx_q, idx_d;
  logic         err_to_q, err_to_d, err_ov_q, err_ov_d;
  logic         in_frame, tmo_expired, last_byte;
`ifdef ALU_LOADER_CHECKSUM_EN
  logic [7:0]   csum_q, csum_d;
  logic         err_ck_q, err_ck_d;
`endif

  assign in_frame  = (state_q != ST_IDLE) && (state_q != ST_ISSUE);
  assign last_byte = (idx_q == 2'(NB - 1));

  // Any byte seen inside a frame restarts the idle window.
  alu_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!in_frame || rx_valid),
    .en_i     (in_frame && !rx_valid),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    err_to_d = 1'b0;
    err_ov_d = 1'b0;
`ifdef ALU_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
    err_ck_d = 1'b0;
`endif
    // Expiry beats a byte arriving in the same cycle.
    if (in_frame && tmo_expired) begin
      state_d  = ST_IDLE;
      err_to_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_valid && (rx_data == FRAME_HDR)) state_d = ST_OPCODE;
        end
        ST_OPCODE: begin
          if (rx_valid) begin
            opcode_d = rx_data;
            idx_d    = '0;
            state_d  = ST_A_BYTES;
`ifdef ALU_LOADER_CHECKSUM_EN
            csum_d   = rx_data;
`endif
          end
        end
        ST_A_BYTES: begin
          if (rx_valid) begin
            a_d   = (a_q << 8) | N'(rx_data);
            idx_d = last_byte ? 2'd0 : idx_q + 2'd1;
            if (last_byte) state_d = ST_B_BYTES;
`ifdef ALU_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ rx_data;
`endif
          end
        end
        ST_B_BYTES: begin
          if (rx_valid) begin
            b_d   = (b_q << 8) | N'(rx_data);
            idx_d = last_byte ? 2'd0 : idx_q + 2'd1;
`ifdef ALU_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ rx_data;
            if (last_byte) state_d = ST_CHECK;
`else
            if (last_byte) state_d = ST_ISSUE;
`endif
          end
        end
`ifdef ALU_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_valid) begin
            if (rx_data == csum_q) begin
              state_d = ST_ISSUE;
            end else begin
              state_d  = ST_IDLE;
              err_ck_d = 1'b1;
            end
          end
        end
`endif
        ST_ISSUE: begin
          if (rx_valid) err_ov_d = 1'b1;
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
`ifdef ALU_LOADER_CHECKSUM_EN
      csum_q   <= '0;
      err_ck_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
`ifdef ALU_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
      err_ck_q <= err_ck_d;
`endif
    end
  end

  assign out_valid   = (state_q == ST_ISSUE);
  assign opcode      = opcode_q;
  assign a           = a_q;
  assign b           = b_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;
`ifdef ALU_LOADER_CHECKSUM_EN
  assign err_checksum = err_ck_q;
`else
  assign err_checksum = 1'b0;
`endif

endmodule
